// File: rtl/imem_arbiter.sv
// Two-requester instruction-memory port arbiter: round-robin on ties, locked bursts
// for atomic cache-line refills, and a ready handshake that tolerates any memory latency.
module imem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_r0_addr,
  input  logic                  i_r0_rd,
  input  logic                  i_r0_lock,
  output logic                  o_r0_gnt,
  output logic [DATA_WIDTH-1:0] o_r0_data,
  output logic                  o_r0_valid,
  input  logic [ADDR_WIDTH-1:0] i_r1_addr,
  input  logic                  i_r1_rd,
  input  logic                  i_r1_lock,
  output logic                  o_r1_gnt,
  output logic [DATA_WIDTH-1:0] o_r1_data,
  output logic                  o_r1_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_ready,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic owner, owner_nxt;
  logic last_owner, last_owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [DATA_WIDTH-1:0] r0_data_q, r1_data_q;
  logic capture;
  logic own_rd, own_lock;

  assign own_rd   = owner ? i_r1_rd   : i_r0_rd;
  assign own_lock = owner ? i_r1_lock : i_r0_lock;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
      r0_data_q  <= '0;
      r1_data_q  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      if (capture && !owner) r0_data_q <= i_mem_data;
      if (capture && owner)  r1_data_q <= i_mem_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        if (i_r0_rd || i_r1_rd) begin
          // On a tie the requester that did not own the port last time wins.
          owner_nxt    = (i_r0_rd && i_r1_rd) ? ~last_owner : i_r1_rd;
          beat_cnt_nxt = '0;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        if (i_mem_ready) begin
          capture      = 1'b1;
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          state_nxt    = DONE;
        end
      end
      DONE: begin
        if (own_lock && own_rd && (beat_cnt < BURST_LIM)) begin
          state_nxt = ACCESS;
        end else begin
          last_owner_nxt = owner;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != IDLE);
    o_mem_rd   = (state == ACCESS);
    o_mem_addr = '0;
    if (state == ACCESS) o_mem_addr = owner ? i_r1_addr : i_r0_addr;
    o_r0_gnt   = (state == ACCESS || state == DONE) && !owner;
    o_r1_gnt   = (state == ACCESS || state == DONE) && owner;
    o_r0_valid = (state == DONE) && !owner;
    o_r1_valid = (state == DONE) && owner;
    o_r0_data  = r0_data_q;
    o_r1_data  = r1_data_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: requester agents, a latency-programmable memory model and a
// scoreboard of expected (requester, data) beats in service order.
module tb_imem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] i_r0_addr, i_r1_addr;
  logic          i_r0_rd, i_r0_lock, i_r1_rd, i_r1_lock;
  logic          o_r0_gnt, o_r0_valid, o_r1_gnt, o_r1_valid;
  logic [DW-1:0] o_r0_data, o_r1_data;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_ready;
  logic          o_busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_r0_addr(i_r0_addr), .i_r0_rd(i_r0_rd), .i_r0_lock(i_r0_lock),
    .o_r0_gnt(o_r0_gnt), .o_r0_data(o_r0_data), .o_r0_valid(o_r0_valid),
    .i_r1_addr(i_r1_addr), .i_r1_rd(i_r1_rd), .i_r1_lock(i_r1_lock),
    .o_r1_gnt(o_r1_gnt), .o_r1_data(o_r1_data), .o_r1_valid(o_r1_valid),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .i_mem_data(i_mem_data),
    .i_mem_ready(i_mem_ready), .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mf(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  typedef struct { bit req; logic [31:0] data; } exp_t;
  typedef struct { bit req; int cyc; } vrec_t;
  exp_t  sb[$];
  vrec_t vq[$];

  // Requester agents: each holds rd until its job's beats are served.
  int unsigned   beats[2];
  int unsigned   served[2];
  int unsigned   lockn[2];
  logic [31:0]   base[2];
  int unsigned   mem_wait = 0;
  bit            junk = 1'b0;
  int unsigned   wcnt = 0;

  task automatic drive();
    logic        act[2];
    logic [31:0] ad[2];
    logic        lk[2];
    for (int n = 0; n < 2; n++) begin
      act[n] = served[n] < beats[n];
      ad[n]  = act[n] ? base[n] + 32'(4 * served[n]) : 32'h0;
      lk[n]  = act[n] && (served[n] < lockn[n]);
    end
    i_r0_rd = act[0]; i_r0_addr = ad[0]; i_r0_lock = lk[0];
    i_r1_rd = act[1]; i_r1_addr = ad[1]; i_r1_lock = lk[1];
  endtask

  task automatic launch(input int n, input logic [31:0] addr, input int unsigned nb,
                        input int unsigned nl);
    base[n] = addr; beats[n] = nb; lockn[n] = nl; served[n] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n = 0;
    while ((served[0] < beats[0] || served[1] < beats[1] || o_busy || sb.size() != 0)
           && n < limit) begin
      tick();
      n++;
    end
    check("wait_done_timeout", 64'(n >= limit), 64'(0));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    drive();
  end

  // Memory model: ready after mem_wait extra cycles of o_mem_rd.
  always @(negedge clk) begin
    if (o_mem_rd) begin
      if (wcnt == mem_wait) begin
        i_mem_ready = 1'b1;
        i_mem_data  = mf(o_mem_addr);
      end else begin
        i_mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt        = 0;
      i_mem_ready = junk;
      i_mem_data  = junk ? 32'hBAD0BAD0 : 32'h0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic v;
    check("gnt_exclusive", 64'(o_r0_gnt && o_r1_gnt), 64'(0));
    if (o_mem_rd && o_r0_gnt) check("r0_rd_held", 64'(i_r0_rd), 64'(1));
    if (o_mem_rd && o_r1_gnt) check("r1_rd_held", 64'(i_r1_rd), 64'(1));
    for (int n = 0; n < 2; n++) begin
      v = (n == 0) ? o_r0_valid : o_r1_valid;
      if (v) begin
        vq.push_back('{bit'(n), cyc});
        served[n]++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: r%0d valid with empty scoreboard", n);
        end else begin
          e = sb.pop_front();
          check("sb_req", 64'(n), 64'(e.req));
          check("sb_data", (n == 0) ? o_r0_data : o_r1_data, e.data);
        end
      end
    end
  end

  typedef struct {
    bit          use0;
    bit          use1;
    logic [31:0] a0;
    logic [31:0] a1;
    int unsigned wt;
    bit          first;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int   L;
    int   exp_b[5];
    int   exp_m[11];
    logic [31:0] r0_last;

    tbl[0] = '{1'b1, 1'b0, 32'h200, 32'h0,   0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0,   32'h300, 2, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h210, 32'h310, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h220, 32'h0,   1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h230, 32'h330, 0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'h240, 32'h340, 1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h0,   32'h350, 3, 1'b1};

    rst_n = 1'b0;
    i_r0_rd = 0; i_r0_lock = 0; i_r0_addr = '0;
    i_r1_rd = 0; i_r1_lock = 0; i_r1_addr = '0;
    i_mem_ready = 0; i_mem_data = '0;
    #12;
    check("rst_busy", 64'(o_busy), 0);
    check("rst_mem_rd", 64'(o_mem_rd), 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_gnt", 64'({o_r0_gnt, o_r1_gnt}), 0);
    check("rst_valid", 64'({o_r0_valid, o_r1_valid}), 0);
    check("rst_r0_data", o_r0_data, 0);
    check("rst_r1_data", o_r1_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single r0 read, memory ready in the first ACCESS cycle.
    sb.push_back('{1'b0, mf(32'h100)});
    launch(0, 32'h100, 1, 0);
    drive();
    tick();
    check("t1_mem_rd", 64'(o_mem_rd), 1);
    check("t1_mem_addr", o_mem_addr, 32'h100);
    check("t1_gnt0", 64'(o_r0_gnt), 1);
    tick();
    check("t1_valid", 64'(o_r0_valid), 1);
    check("t1_data", o_r0_data, 32'hDEADBEEF);
    check("t1_mem_rd_done", 64'(o_mem_rd), 0);
    tick();
    check("t1_idle", 64'(o_busy), 0);
    wait_done(50);

    foreach (tbl[i]) begin
      vq.delete();
      if (tbl[i].use0 && tbl[i].use1) begin
        sb.push_back('{tbl[i].first, mf(tbl[i].first ? tbl[i].a1 : tbl[i].a0)});
        sb.push_back('{!tbl[i].first, mf(tbl[i].first ? tbl[i].a0 : tbl[i].a1)});
      end else if (tbl[i].use0) begin
        sb.push_back('{1'b0, mf(tbl[i].a0)});
      end else begin
        sb.push_back('{1'b1, mf(tbl[i].a1)});
      end
      if (tbl[i].use0) launch(0, tbl[i].a0, 1, 0);
      if (tbl[i].use1) launch(1, tbl[i].a1, 1, 0);
      mem_wait = tbl[i].wt;
      L = cyc;
      drive();
      wait_done(200);
      check("vec_count", 64'(vq.size()), (tbl[i].use0 && tbl[i].use1) ? 2 : 1);
      if (vq.size() >= 1) check("vec_lat1", 64'(vq[0].cyc - L), 64'(tbl[i].wt + 2));
      if (vq.size() >= 2) check("vec_lat2", 64'(vq[1].cyc - L), 64'(2 * tbl[i].wt + 5));
    end

    // Locked 4-beat r0 burst with r1 waiting: back-to-back beats, r1 right after.
    vq.delete();
    mem_wait = 0;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, mf(32'h1000 + 32'(4 * i))});
    sb.push_back('{1'b1, mf(32'h2000)});
    launch(0, 32'h1000, 4, 3);
    L = cyc;
    drive();
    tick();
    launch(1, 32'h2000, 1, 0);
    drive();
    wait_done(200);
    exp_b = '{2, 4, 6, 8, 11};
    check("burst_count", 64'(vq.size()), 5);
    for (int i = 0; i < 5 && i < vq.size(); i++) check("burst_cyc", 64'(vq[i].cyc - L), 64'(exp_b[i]));

    // Lock held past MAX_BURST: forced release after 8, r1 served, r0 resumes.
    vq.delete();
    for (int i = 0; i < 8; i++) sb.push_back('{1'b0, mf(32'h4000 + 32'(4 * i))});
    sb.push_back('{1'b1, mf(32'h5000)});
    for (int i = 8; i < 10; i++) sb.push_back('{1'b0, mf(32'h4000 + 32'(4 * i))});
    launch(0, 32'h4000, 10, 9);
    L = cyc;
    drive();
    tick();
    launch(1, 32'h5000, 1, 0);
    drive();
    wait_done(300);
    exp_m = '{2, 4, 6, 8, 10, 12, 14, 16, 19, 22, 24};
    check("maxb_count", 64'(vq.size()), 11);
    for (int i = 0; i < 11 && i < vq.size(); i++) check("maxb_cyc", 64'(vq[i].cyc - L), 64'(exp_m[i]));

    // Five-cycle memory wait: strobe and address stable, valid right after ready.
    mem_wait = 5;
    sb.push_back('{1'b0, mf(32'h600)});
    launch(0, 32'h600, 1, 0);
    drive();
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("wait_mem_rd", 64'(o_mem_rd), 1);
      check("wait_mem_addr", o_mem_addr, 32'h600);
      check("wait_no_valid", 64'(o_r0_valid), 0);
    end
    tick();
    check("wait_valid", 64'(o_r0_valid), 1);
    check("wait_mem_rd_off", 64'(o_mem_rd), 0);
    wait_done(50);
    r0_last = mf(32'h600);

    // Stray ready while idle must be ignored; captured data holds.
    junk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("junk_busy", 64'(o_busy), 0);
      check("junk_r0_data", o_r0_data, r0_last);
      check("junk_r1_data", o_r1_data, mf(32'h5000));
    end
    junk = 1'b0;
    tick();

    // Asynchronous reset in the middle of an access.
    mem_wait = 3;
    launch(0, 32'h700, 1, 0);
    drive();
    tick();
    tick();
    check("pre_rst_mem_rd", 64'(o_mem_rd), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_mem_rd", 64'(o_mem_rd), 0);
    check("arst_gnt", 64'({o_r0_gnt, o_r1_gnt}), 0);
    check("arst_valid", 64'({o_r0_valid, o_r1_valid}), 0);
    check("arst_busy", 64'(o_busy), 0);
    check("arst_r0_data", o_r0_data, 0);
    beats[0] = 0; served[0] = 0; beats[1] = 0; served[1] = 0;
    drive();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vq.delete();
    mem_wait = 0;
    sb.push_back('{1'b0, mf(32'h800)});
    sb.push_back('{1'b1, mf(32'h900)});
    launch(0, 32'h800, 1, 0);
    launch(1, 32'h900, 1, 0);
    L = cyc;
    drive();
    wait_done(100);
    check("post_rst_count", 64'(vq.size()), 2);
    if (vq.size() >= 1) begin
      check("post_rst_first", 64'(vq[0].req), 0);
      check("post_rst_lat", 64'(vq[0].cyc - L), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Two-requester arbiter that shares the single instruction-memory read port between the instruction cache refill path (requester 0) and a secondary read port (requester 1, e.g. debug/loader).
- Sits between the ICache memory interface and the instruction memory.
- Provides round-robin fairness, locked bursts so cache lines refill atomically, and a request/ready handshake to the memory so it tolerates variable latency.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, width of read data.
- MAX_BURST, 8, maximum consecutive beats one owner may hold under lock before forced release (≥1).

Ports:
- i_clock  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous active-low reset
- i_r0_addr  in  ADDR_WIDTH  requester 0 read address
- i_r0_rd  in  1  requester 0 read request
- i_r0_lock  in  1  requester 0 wants to keep grant after this beat
- o_r0_gnt  out  1  requester 0 owns the memory port
- o_r0_data  out  DATA_WIDTH  requester 0 read data
- o_r0_valid  out  1  one-cycle pulse: o_r0_data valid
- i_r1_addr, i_r1_rd, i_r1_lock, o_r1_gnt, o_r1_data, o_r1_valid  same as above for requester 1
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_rd  out  1  memory read strobe
- i_mem_data  in  DATA_WIDTH  memory read data
- i_mem_ready  in  1  memory data valid this cycle
- o_busy  out  1  arbiter not IDLE

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE, owner=0, last_owner=1 (so r0 wins the first tie), beat count=0.
  - All outputs 0, including data registers.
  - Any in-flight memory access is abandoned; o_mem_rd drops immediately.
- FSM states:
  - IDLE: arbitrate. Single requester → grant it. Both requesting → grant the one ≠ last_owner. Register owner, clear beat count, go ACCESS. No request → stay.
  - ACCESS: o_mem_rd=1; o_mem_addr = owner's i_rN_addr (combinational pass-through; requester holds it stable). On i_mem_ready: capture i_mem_data into owner's o_rN_data, increment beat count, go DONE. Otherwise stay (no timeout).
  - DONE: o_rN_valid=1 for owner for exactly this cycle; o_mem_rd=0.
    - If owner's lock=1, owner's rd=1 and beat count < MAX_BURST: go ACCESS, same owner, regardless of the other requester.
    - Else: last_owner ← owner, go IDLE.
- o_rN_gnt=1 only in ACCESS/DONE while owner=N; never both grants at once.
- o_busy = (state != IDLE).
- o_mem_addr = 0 outside ACCESS.
- Latency: rd seen in IDLE at cycle 0 → ACCESS at cycle 1 → ready at cycle k≥1 → valid at cycle k+1 → IDLE at k+2.
- Locked burst beats repeat every 2+memory-wait cycles with no IDLE gap.
- Boundaries and illegal conditions:
  - i_mem_ready outside ACCESS: ignored.
  - Owner drops rd during ACCESS: illegal (bench asserts). RTL still completes the beat and pulses valid.
  - Beat count reaching MAX_BURST forces release even with lock=1; the other requester, if requesting, wins the next IDLE.
  - Lock asserted on a non-owner: no effect.
  - o_rN_data holds its last captured value until the next capture for that requester.

Test Plan:
- Reset then r0 rd addr 0x100, memory ready 1 cycle after o_mem_rd → o_mem_addr=0x100 at cycle 1; o_r0_valid at cycle 2 with mem data 0xDEADBEEF; o_busy low at cycle 3.
- r0 and r1 assert rd same cycle after reset → r0 granted first; r1 granted in the next IDLE; repeat the simultaneous request → r1 granted first (alternation).
- r0 locked burst of 4 beats (lock=1 on beats 1-3), r1 requesting throughout → 4 consecutive r0 beats, no IDLE between; r1 granted immediately after beat 4.
- r0 lock held for 10 beats with MAX_BURST=8, r1 requesting → release after beat 8; r1 served; r0 resumes afterwards.
- Memory wait of 5 cycles → o_mem_rd and o_mem_addr stable all 5 cycles; valid exactly one cycle after ready.
- Assert i_reset low mid-ACCESS → o_mem_rd, grants, valids and o_busy go 0 asynchronously; after release, first request is served normally with r0 winning a tie.
